addsub_pipe: RTL and testbench

- Parametrised, pipelined integer add/subtract unit for the MIPS datapath; successor to the single-cycle 32-bit adder.
- Splits the carry chain into STAGES equal slices, one slice per pipeline stage, for timing closure at higher clock rates.
- Supports signed and unsigned add/sub, MIPS-style overflow detection, carry, zero flag, a tag passthrough, and valid/ready back-pressure.
- Sits between the ID/EX operand muxes and the EX/MEM result path.

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_slice.sv | 26 ++
 rtl/addsub_pipe.sv | 160 ++++++++++++++++
 tb/tb_addsub_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings and slice helpers.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDU = 2'b10,
      OP_SUBU = 2'b11
   } addsub_op_e;

   function automatic int unsigned slice_width(input int unsigned width,
                                               input int unsigned stages);
      return width / stages;
   endfunction

   function automatic logic op_is_sub(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_SUBU);
   endfunction

   function automatic logic op_is_unsigned(input logic [1:0] op);
      return (op == OP_ADDU) || (op == OP_SUBU);
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CW-bit ripple-carry adder slice; one per pipeline stage.
module addsub_slice #(
   parameter int unsigned CW = 16
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          cin_i,
   output logic [CW-1:0] sum_o,
   output logic          cout_o
);

   logic [CW:0] c;

   always_comb begin
      c     = '0;
      sum_o = '0;
      c[0]  = cin_i;
      for (int i = 0; i < CW; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign cout_o = c[CW];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit; carry chain split into STAGES slices, one per stage.
// Defining ADDSUB_PIPE_FLUSH_EN adds a `flush` input that drops every in-flight beat.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
`ifdef ADDSUB_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned CW  = slice_width(WIDTH, STAGES);
   localparam int unsigned L   = STAGES - 1;
   localparam int unsigned MSB = WIDTH - 1;

   logic flush_int;
`ifdef ADDSUB_PIPE_FLUSH_EN
   assign flush_int = flush;
`else
   assign flush_int = 1'b0;
`endif

   // Pipeline rank k holds the state produced by stage k.
   logic [STAGES-1:0]            vld_q;
   logic [STAGES-1:0][WIDTH-1:0] a_q;
   logic [STAGES-1:0][WIDTH-1:0] b_q;
   logic [STAGES-1:0][WIDTH-1:0] res_q;
   logic [STAGES-1:0]            cry_q;
   logic [STAGES-1:0][1:0]       op_q;
   logic [STAGES-1:0][TAG_W-1:0] tag_q;
   logic                         ovf_q;
   logic                         zero_q;

   // Stage inputs (from ports for stage 0, from the previous rank otherwise).
   logic [STAGES-1:0]            s_vld;
   logic [STAGES-1:0]            s_cin;
   logic [STAGES-1:0][WIDTH-1:0] s_a;
   logic [STAGES-1:0][WIDTH-1:0] s_b;
   logic [STAGES-1:0][WIDTH-1:0] s_res;
   logic [STAGES-1:0][1:0]       s_op;
   logic [STAGES-1:0][TAG_W-1:0] s_tag;

   // Stage outputs.
   logic [STAGES-1:0][WIDTH-1:0] n_res;
   logic [STAGES-1:0]            n_cry;

   logic stall;
   logic ovf_d;
   logic zero_d;

   assign stall    = vld_q[L] && !out_ready;
   assign in_ready = !rst && !stall && !flush_int;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] SliceMask = WIDTH'({CW{1'b1}}) << (k * CW);

      logic [CW-1:0] sum;

      if (k == 0) begin : g_first
         assign s_vld[0] = in_valid && in_ready;
         assign s_a[0]   = in_a;
         assign s_b[0]   = op_is_sub(in_op) ? ~in_b : in_b;
         assign s_res[0] = '0;
         assign s_cin[0] = op_is_sub(in_op);
         assign s_op[0]  = in_op;
         assign s_tag[0] = in_tag;
      end else begin : g_next
         assign s_vld[k] = vld_q[k-1];
         assign s_a[k]   = a_q[k-1];
         assign s_b[k]   = b_q[k-1];
         assign s_res[k] = res_q[k-1];
         assign s_cin[k] = cry_q[k-1];
         assign s_op[k]  = op_q[k-1];
         assign s_tag[k] = tag_q[k-1];
      end

      addsub_slice #(
         .CW (CW)
      ) u_slice (
         .a_i    (s_a[k][k*CW +: CW]),
         .b_i    (s_b[k][k*CW +: CW]),
         .cin_i  (s_cin[k]),
         .sum_o  (sum),
         .cout_o (n_cry[k])
      );

      // Merge this stage's slice into the partial result carried down the pipe.
      assign n_res[k] = (s_res[k] & ~SliceMask) | ((WIDTH'(sum)) << (k * CW));
   end

   always_comb begin
      ovf_d  = !op_is_unsigned(s_op[L]) &&
               (s_a[L][MSB] == s_b[L][MSB]) &&
               (n_res[L][MSB] != s_a[L][MSB]);
      zero_d = (n_res[L] == '0);
   end

   // Flush overrides stall; data registers only load on a valid beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         cry_q  <= '0;
         op_q   <= '0;
         tag_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (flush_int) begin
         vld_q <= '0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= s_vld[k];
            if (s_vld[k]) begin
               a_q[k]   <= s_a[k];
               b_q[k]   <= s_b[k];
               res_q[k] <= n_res[k];
               cry_q[k] <= n_cry[k];
               op_q[k]  <= s_op[k];
               tag_q[k] <= s_tag[k];
            end
         end
         if (s_vld[L]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign out_valid  = vld_q[L];
   assign out_result = res_q[L];
   assign out_carry  = cry_q[L];
   assign out_ovf    = ovf_q;
   assign out_zero   = zero_q;
   assign out_tag    = tag_q[L];

   // Last-rank operand skew and already-consumed low slices have no reader.
   logic unused_skew;
   assign unused_skew = ^{a_q[L], b_q[L], op_q[L], s_a, s_b};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed vectors, random back-pressure run and
// reset/flush corner cases, checked against an arithmetic reference model.
module tb_addsub_pipe;
   import addsub_pkg::*;

   parameter int unsigned WIDTH  = 32;
   parameter int unsigned STAGES = 2;
   parameter int unsigned TAG_W  = 5;

   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL1 = '1;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush_tb;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_ovf;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   addsub_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef ADDSUB_PIPE_FLUSH_EN
      .flush      (flush_tb),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_ovf    (out_ovf),
      .out_zero   (out_zero),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   logic        chk_lat = 1'b0;

   always @(posedge clk) cyc++;

   typedef struct {
      logic [WIDTH-1:0] result;
      logic             carry;
      logic             ovf;
      logic             zero;
      logic [TAG_W-1:0] tag;
   } exp_t;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       op;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] res;
      logic             c;
      logic             v;
      logic             z;
   } vec_t;

   exp_t        expq[$];
   int unsigned accq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: exact integer arithmetic, then reduce to WIDTH bits and flags.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [1:0] op, input logic [TAG_W-1:0] tag);
      exp_t    e;
      longint  sa, sb, ua, ub, xs, xu;
      longint  maxs, mins;
      logic    sub, uns;
      sub  = (op == OP_SUB) || (op == OP_SUBU);
      uns  = (op == OP_ADDU) || (op == OP_SUBU);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = longint'(a);
      ub   = longint'(b);
      xs   = sub ? sa - sb : sa + sb;
      xu   = sub ? ua - ub : ua + ub;
      maxs = (longint'(1) << (WIDTH - 1)) - 1;
      mins = -(longint'(1) << (WIDTH - 1));
      e.result = xu[WIDTH-1:0];
      e.carry  = sub ? (ua >= ub) : (xu >= (longint'(1) << WIDTH));
      e.ovf    = !uns && ((xs > maxs) || (xs < mins));
      e.zero   = (e.result == '0);
      e.tag    = tag;
      return e;
   endfunction

   // Output monitor: scoreboard, stall stability, in_ready under stall/flush.
   logic stalled = 1'b0;
   exp_t held;
   always @(negedge clk) begin
      exp_t        e;
      int unsigned t;
      if (rst || flush_tb) begin
         if (flush_tb) check("in_ready_flush", 64'(in_ready), 64'(0));
         expq.delete();
         accq.delete();
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_result", 64'(out_result), 64'(held.result));
            check("stall_flags", 64'({out_carry, out_ovf, out_zero}),
                  64'({held.carry, held.ovf, held.zero}));
            check("stall_tag", 64'(out_tag), 64'(held.tag));
         end
         if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(0));
         stalled     = out_valid && !out_ready;
         held.result = out_result;
         held.carry  = out_carry;
         held.ovf    = out_ovf;
         held.zero   = out_zero;
         held.tag    = out_tag;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got out_valid=1 with nothing pending, required 0");
            end else begin
               e = expq.pop_front();
               t = accq.pop_front();
               check("sb_result", 64'(out_result), 64'(e.result));
               check("sb_carry", 64'(out_carry), 64'(e.carry));
               check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
               check("sb_zero", 64'(out_zero), 64'(e.zero));
               check("sb_tag", 64'(out_tag), 64'(e.tag));
               if (chk_lat) check("sb_latency", 64'(cyc - t), 64'(STAGES));
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(in_a, in_b, in_op, in_tag));
            accq.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic [TAG_W-1:0] tag);
      logic acc;
      acc      = 1'b0;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_accepted", 64'(acc), 64'(1));
   endtask

   // Called #1 after the accept edge; returns edges from accept to out_valid (0 = timeout).
   task automatic wait_out(output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (out_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int k = 0; k < 200 && expq.size() != 0; k++) @(posedge clk);
      #1;
      check(name, 64'(expq.size()), 64'(0));
   endtask

   initial begin
      vec_t tbl[$];
      int   lat;
      int   sent;
      logic acc;
      logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst       = 1'b1;
      flush_tb  = 1'b0;
      in_valid  = 1'b1;
      in_a      = WIDTH'(7);
      in_b      = WIDTH'(9);
      in_op     = OP_ADD;
      in_tag    = TAG_W'(1);
      out_ready = 1'b1;

      // Reset state; in_valid held high throughout must not be captured.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_result", 64'(out_result), 64'(0));
      check("rst_out_flags", 64'({out_carry, out_ovf, out_zero}), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      repeat (STAGES + 2) begin
         @(posedge clk);
         #1;
         check("rst_no_capture", 64'(out_valid), 64'(0));
      end

      // Directed vectors.
      tbl.push_back('{"add_ovf", MAXP, WIDTH'(1), OP_ADD, TAG_W'(2), MINN, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{"addu_wrap", ALL1, WIDTH'(1), OP_ADDU, TAG_W'(17), '0, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{"sub_ovf", MINN, WIDTH'(1), OP_SUB, TAG_W'(3), MAXP, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{"subu_borrow", WIDTH'(3), WIDTH'(5), OP_SUBU, TAG_W'(4), ALL1 - WIDTH'(1),
                      1'b0, 1'b0, 1'b0});
      tbl.push_back('{"add_small", WIDTH'(10), WIDTH'(20), OP_ADD, TAG_W'(5), WIDTH'(30),
                      1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sub_equal", WIDTH'(5), WIDTH'(5), OP_SUB, TAG_W'(6), '0, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{"add_neg_ovf", MINN, MINN, OP_ADD, TAG_W'(7), '0, 1'b1, 1'b1, 1'b1});
      tbl.push_back('{"addu_no_ovf", MAXP, WIDTH'(1), OP_ADDU, TAG_W'(8), MINN, 1'b0, 1'b0, 1'b0});

      chk_lat = 1'b1;
      foreach (tbl[i]) begin
         send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag);
         wait_out(lat);
         check({tbl[i].name, "_latency"}, 64'(lat), 64'(STAGES));
         check({tbl[i].name, "_result"}, 64'(out_result), 64'(tbl[i].res));
         check({tbl[i].name, "_carry"}, 64'(out_carry), 64'(tbl[i].c));
         check({tbl[i].name, "_ovf"}, 64'(out_ovf), 64'(tbl[i].v));
         check({tbl[i].name, "_zero"}, 64'(out_zero), 64'(tbl[i].z));
         check({tbl[i].name, "_tag"}, 64'(out_tag), 64'(tbl[i].tag));
      end
      drain("table_drain");
      chk_lat = 1'b0;

      // Random beats under 1,0,0,1 back-pressure; beat held until accepted.
      sent = 0;
      for (int i = 0; i < 2000 && sent < 32; i++) begin
         if (i == 0 || acc || !in_valid) begin
            in_a     = ($urandom_range(0, 3) == 0) ? MAXP : WIDTH'($urandom);
            in_b     = ($urandom_range(0, 3) == 0) ? MINN : WIDTH'($urandom);
            in_op    = 2'($urandom_range(0, 3));
            in_tag   = TAG_W'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = pat[i % 4];
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      in_valid = 1'b0;
      check("rand_sent", 64'(sent), 64'(32));
      drain("rand_drain");

      // Reset with beats in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = WIDTH'(100);
      in_b      = WIDTH'(1);
      in_op     = OP_ADD;
      in_tag    = TAG_W'(9);
      @(posedge clk);
      #1;
      in_a = WIDTH'(200);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_result_cleared", 64'(out_result), 64'(0));
      out_ready = 1'b1;
      repeat (STAGES + 3) begin
         check("midrst_no_valid", 64'(out_valid), 64'(0));
         @(posedge clk);
         #1;
      end
      chk_lat = 1'b1;
      send(WIDTH'(10), WIDTH'(20), OP_ADD, TAG_W'(11));
      wait_out(lat);
      check("midrst_next_latency", 64'(lat), 64'(STAGES));
      check("midrst_next_result", 64'(out_result), 64'(30));
      drain("midrst_drain");

`ifdef ADDSUB_PIPE_FLUSH_EN
      // Flush with beats in flight and a same-cycle input.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = WIDTH'(1);
      in_b      = WIDTH'(2);
      @(posedge clk);
      #1;
      in_a = WIDTH'(3);
      @(posedge clk);
      #1;
      flush_tb = 1'b1;
      in_a     = WIDTH'(5);
      @(posedge clk);
      #1;
      flush_tb = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (STAGES + 3) begin
         check("flush_no_valid", 64'(out_valid), 64'(0));
         @(posedge clk);
         #1;
      end
      send(WIDTH'(40), WIDTH'(2), OP_SUB, TAG_W'(12));
      wait_out(lat);
      check("flush_next_latency", 64'(lat), 64'(STAGES));
      check("flush_next_result", 64'(out_result), 64'(38));
      drain("flush_drain");
`endif

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
